// File: rtl/pcf8563_slave_pkg.sv
// Shared constants for the PCF8563 register-interface I2C target.
package pcf8563_slave_pkg;

    localparam logic [6:0] DEF_DEV_ADDR = 7'h51;
    localparam int         DEF_REG_NUM  = 16;
    localparam int         PTR_W        = $clog2(DEF_REG_NUM);

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE      = 4'd0;
    localparam state_t ST_ADDR      = 4'd1;
    localparam state_t ST_ADDR_ACK  = 4'd2;
    localparam state_t ST_WPTR      = 4'd3;
    localparam state_t ST_WPTR_ACK  = 4'd4;
    localparam state_t ST_WDATA     = 4'd5;
    localparam state_t ST_WDATA_ACK = 4'd6;
    localparam state_t ST_RDATA     = 4'd7;
    localparam state_t ST_RACK      = 4'd8;
    localparam state_t ST_WAIT_P    = 4'd9;

    localparam logic [3:0] REG_CONTROL_1     = 4'h0;
    localparam logic [3:0] REG_CONTROL_2     = 4'h1;
    localparam logic [3:0] REG_SECONDS       = 4'h2;
    localparam logic [3:0] REG_MINUTES       = 4'h3;
    localparam logic [3:0] REG_HOURS         = 4'h4;
    localparam logic [3:0] REG_DAYS          = 4'h5;
    localparam logic [3:0] REG_WEEKDAYS      = 4'h6;
    localparam logic [3:0] REG_CENTURY_MONTH = 4'h7;
    localparam logic [3:0] REG_YEARS         = 4'h8;

endpackage

// File: rtl/pcf8563_i2c_slave_if.sv
// Write-observation and status port of the I2C target; slave drives, master watches.
interface pcf8563_i2c_slave_if
    import pcf8563_slave_pkg::*;
#(
    parameter int AW = PTR_W
);
    logic          wr_strobe;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          busy;

    modport slave  (output wr_strobe, wr_addr, wr_data, busy);
    modport master (input  wr_strobe, wr_addr, wr_data, busy);
endinterface

// File: rtl/pcf8563_i2c_slave_pin_sync.sv
// SCL/SDA 2-FF synchronizers plus edge register; events appear 3 clk after the pin edge.
// sda_s is aligned with the events so a receiver samples it together with scl_rise.
module i2c_pin_sync (
    input  logic clk,
    input  logic rstn,
    input  logic scl,
    input  logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);
    logic [1:0] scl_sy;
    logic [1:0] sda_sy;
    logic       scl_q;
    logic       sda_q;

    // Reset to the idle bus level so releasing reset never fakes an edge on a quiet bus.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            scl_sy    <= 2'b11;
            sda_sy    <= 2'b11;
            scl_q     <= 1'b1;
            sda_q     <= 1'b1;
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
        end else begin
            scl_sy    <= {scl_sy[0], scl};
            sda_sy    <= {sda_sy[0], sda};
            scl_q     <= scl_sy[1];
            sda_q     <= sda_sy[1];
            scl_rise  <= scl_sy[1] & ~scl_q;
            scl_fall  <= ~scl_sy[1] & scl_q;
            start_det <= scl_sy[1] & scl_q & sda_q & ~sda_sy[1];
            stop_det  <= scl_sy[1] & scl_q & ~sda_q & sda_sy[1];
        end
    end

    assign sda_s = sda_q;
endmodule

// File: rtl/pcf8563_i2c_slave.sv
// I2C target emulating the PCF8563 register file; SDA drive changes 1 clk after scl_fall event.
// No backpressure: the bus master owns SCL, this block only ACKs, NACKs by release, or drives read data.
module pcf8563_i2c_slave
    import pcf8563_slave_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = DEF_DEV_ADDR,
    parameter int          REG_NUM  = DEF_REG_NUM
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      i2c_sclk,
    inout  wire                       i2c_sdat,
    pcf8563_i2c_slave_if.slave        obs
);
    localparam int AW = $clog2(REG_NUM);

    logic          scl_rise;
    logic          scl_fall;
    logic          start_det;
    logic          stop_det;
    logic          sda_s;

    state_t        state;
    logic [3:0]    bit_cnt;
    logic [7:0]    rx_sh;
    logic [7:0]    tx_sh;
    logic          rw;
    logic          sda_low;
    logic [AW-1:0] ptr;
    logic [7:0]    regs [REG_NUM];

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(REG_NUM - 1)) ? '0 : p + 1'b1;
    endfunction

    i2c_pin_sync u_pin_sync (
        .clk       (clk),
        .rstn      (rstn),
        .scl       (i2c_sclk),
        .sda       (i2c_sdat),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    // Open drain: sda_low is a reset flop, so reset releases the line without waiting for clk.
    assign i2c_sdat = sda_low ? 1'b0 : 1'bz;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= ST_IDLE;
            bit_cnt       <= '0;
            rx_sh         <= '0;
            tx_sh         <= '0;
            rw            <= 1'b0;
            sda_low       <= 1'b0;
            ptr           <= '0;
            obs.wr_strobe <= 1'b0;
            obs.wr_addr   <= '0;
            obs.wr_data   <= '0;
            obs.busy      <= 1'b0;
            for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
        end else begin
            obs.wr_strobe <= 1'b0;
            if (stop_det) begin
                state    <= ST_IDLE;
                sda_low  <= 1'b0;
                obs.busy <= 1'b0;
            end else if (start_det) begin
                state   <= ST_ADDR;
                bit_cnt <= '0;
                sda_low <= 1'b0;
            end else begin
                if (scl_rise) begin
                    case (state)
                        ST_ADDR, ST_WPTR, ST_WDATA: begin
                            if (bit_cnt != 4'd8) begin
                                rx_sh   <= {rx_sh[6:0], sda_s};
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                        ST_RACK: begin
                            if (sda_s) begin
                                state    <= ST_WAIT_P;
                                obs.busy <= 1'b0;
                            end else begin
                                state   <= ST_RDATA;
                                tx_sh   <= regs[ptr];
                                bit_cnt <= '0;
                            end
                        end
                        default: ;
                    endcase
                end
                if (scl_fall) begin
                    case (state)
                        ST_ADDR: begin
                            if (bit_cnt == 4'd8) begin
                                if (rx_sh[7:1] == DEV_ADDR) begin
                                    sda_low  <= 1'b1;
                                    rw       <= rx_sh[0];
                                    obs.busy <= 1'b1;
                                    state    <= ST_ADDR_ACK;
                                end else begin
                                    obs.busy <= 1'b0;
                                    state    <= ST_IDLE;
                                end
                            end
                        end
                        ST_ADDR_ACK: begin
                            // A read must put bit 7 on the line on the same fall that ends the ACK.
                            if (rw) begin
                                state   <= ST_RDATA;
                                sda_low <= ~regs[ptr][7];
                                tx_sh   <= {regs[ptr][6:0], 1'b0};
                                bit_cnt <= 4'd1;
                            end else begin
                                state   <= ST_WPTR;
                                sda_low <= 1'b0;
                                bit_cnt <= '0;
                            end
                        end
                        ST_WPTR: begin
                            if (bit_cnt == 4'd8) begin
                                ptr     <= rx_sh[AW-1:0];
                                sda_low <= 1'b1;
                                state   <= ST_WPTR_ACK;
                            end
                        end
                        ST_WPTR_ACK, ST_WDATA_ACK: begin
                            sda_low <= 1'b0;
                            bit_cnt <= '0;
                            state   <= ST_WDATA;
                        end
                        ST_WDATA: begin
                            if (bit_cnt == 4'd8) begin
                                regs[ptr]     <= rx_sh;
                                obs.wr_strobe <= 1'b1;
                                obs.wr_addr   <= ptr;
                                obs.wr_data   <= rx_sh;
                                ptr           <= ptr_inc(ptr);
                                sda_low       <= 1'b1;
                                state         <= ST_WDATA_ACK;
                            end
                        end
                        ST_RDATA: begin
                            if (bit_cnt == 4'd8) begin
                                sda_low <= 1'b0;
                                ptr     <= ptr_inc(ptr);
                                state   <= ST_RACK;
                            end else begin
                                sda_low <= ~tx_sh[7];
                                tx_sh   <= {tx_sh[6:0], 1'b0};
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_pcf8563_i2c_slave.sv
// Directed plus randomized I2C master bench for pcf8563_i2c_slave with a register-file reference model.
module tb_pcf8563_i2c_slave;
    import pcf8563_slave_pkg::*;

    logic clk   = 1'b0;
    logic rstn  = 1'b0;
    logic scl   = 1'b1;
    logic m_low = 1'b0;
    wire  sda_bus;

    assign sda_bus = m_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    always #10 clk = ~clk;

    pcf8563_i2c_slave_if obs_if ();

    pcf8563_i2c_slave dut (
        .clk      (clk),
        .rstn     (rstn),
        .i2c_sclk (scl),
        .i2c_sdat (sda_bus),
        .obs      (obs_if)
    );

    int total = 0;
    int bad   = 0;
    int q     = 625;

    logic [7:0]  mregs [16];
    int          mptr;
    logic [7:0]  wbuf [16];
    logic [11:0] strb_q [$];
    logic [11:0] exp_q  [$];

    time last_sda  = 0;
    bit  chk_en    = 1'b0;
    int  hold_viol = 0;
    int  dut_pull  = 0;

    always @(negedge clk) if (obs_if.wr_strobe === 1'b1) strb_q.push_back({obs_if.wr_addr, obs_if.wr_data});
    always @(negedge clk) if (!m_low && sda_bus === 1'b0) dut_pull++;
    always @(sda_bus) last_sda = $time;
    always @(posedge scl) if (chk_en && ($time - last_sda) < 1000) hold_viol++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic clk_bit(input bit drv, output bit smp);
        #40;
        m_low = ~drv;
        #(2*q - 40);
        scl = 1'b1;
        #(q);
        smp = sda_bus;
        #(q);
        scl = 1'b0;
    endtask

    task automatic i2c_start();
        #40;  m_low = 1'b0;
        #(q); scl   = 1'b1;
        #(q); m_low = 1'b1;
        #(q); scl   = 1'b0;
    endtask

    task automatic i2c_stop();
        #40;  m_low = 1'b1;
        #(q); scl   = 1'b1;
        #(q); m_low = 1'b0;
        #(q);
    endtask

    task automatic send_byte(input logic [7:0] b, output bit ack_n);
        bit dmy;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], dmy);
        clk_bit(1'b1, ack_n);
    endtask

    task automatic recv_byte(input bit nack, output logic [7:0] d);
        bit b;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, b);
            d[i] = b;
        end
        clk_bit(nack, b);
    endtask

    task automatic check_strobes(input string tag);
        check({tag, "_nstrb"}, strb_q.size(), exp_q.size());
        for (int i = 0; i < strb_q.size() && i < exp_q.size(); i++)
            check({tag, "_strb"}, strb_q[i], exp_q[i]);
        strb_q.delete();
        exp_q.delete();
    endtask

    task automatic do_write(input logic [6:0] dev, input logic [7:0] p, input int n, input string tag);
        bit a;
        bit hit;
        hit = (dev == DEF_DEV_ADDR);
        i2c_start();
        chk_en = 1'b1;
        send_byte({dev, 1'b0}, a);
        check({tag, "_aack"}, a, hit ? 0 : 1);
        check({tag, "_busy"}, obs_if.busy, hit ? 1 : 0);
        send_byte(p, a);
        check({tag, "_pack"}, a, hit ? 0 : 1);
        if (hit) mptr = p % 16;
        for (int i = 0; i < n; i++) begin
            send_byte(wbuf[i], a);
            check({tag, "_dack"}, a, hit ? 0 : 1);
            if (hit) begin
                mregs[mptr] = wbuf[i];
                exp_q.push_back({4'(mptr), wbuf[i]});
                mptr = (mptr + 1) % 16;
            end
        end
        chk_en = 1'b0;
        i2c_stop();
        check({tag, "_idle"}, obs_if.busy, 0);
        check_strobes(tag);
    endtask

    task automatic do_read(input bit set_ptr, input logic [7:0] p, input int n, input string tag);
        bit a;
        logic [7:0] d;
        i2c_start();
        if (set_ptr) begin
            send_byte({DEF_DEV_ADDR, 1'b0}, a);
            check({tag, "_waack"}, a, 0);
            send_byte(p, a);
            check({tag, "_pack"}, a, 0);
            mptr = p % 16;
            i2c_start();
        end
        send_byte({DEF_DEV_ADDR, 1'b1}, a);
        check({tag, "_raack"}, a, 0);
        for (int i = 0; i < n; i++) begin
            recv_byte(i == n - 1, d);
            check({tag, "_data"}, d, mregs[mptr]);
            mptr = (mptr + 1) % 16;
        end
        check({tag, "_nack_busy"}, obs_if.busy, 0);
        i2c_stop();
        check_strobes(tag);
    endtask

    initial begin
        bit a;
        bit b;
        for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
        mptr = 0;

        #23;
        rstn = 1'b1;
        #200;
        check("rst_busy",   obs_if.busy, 0);
        check("rst_strobe", obs_if.wr_strobe, 0);
        check("rst_waddr",  obs_if.wr_addr, 0);
        check("rst_wdata",  obs_if.wr_data, 0);
        check("rst_sda",    sda_bus, 1);

        // 400 kHz write of seconds/minutes/hours
        hold_viol = 0;
        wbuf[0] = 8'h45; wbuf[1] = 8'h30; wbuf[2] = 8'h12;
        do_write(DEF_DEV_ADDR, 8'h02, 3, "wr_time");
        check("hold_time", hold_viol, 0);
        q = 250;

        do_read(1'b1, 8'h02, 3, "rd_time");

        // wrong device address must stay silent
        dut_pull = 0;
        wbuf[0] = 8'hDE; wbuf[1] = 8'hAD;
        do_write(7'h50, 8'h02, 2, "wr_0x50");
        check("nomatch_pull", dut_pull, 0);
        do_read(1'b1, 8'h02, 3, "rd_after_0x50");

        for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
        do_write(DEF_DEV_ADDR, 8'h0E, 4, "wr_wrap");
        do_read(1'b1, 8'h0E, 4, "rd_wrap");

        for (int k = 0; k < 3; k++) begin
            int n;
            n = $urandom_range(1, 5);
            for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
            do_write(DEF_DEV_ADDR, 8'($urandom_range(0, 255)), n, "wr_rand");
            do_read(k[0], 8'($urandom_range(0, 255)), $urandom_range(1, 4), "rd_rand");
        end

        // reset during bit 3 of a read byte whose bit 3 is 0
        wbuf[0] = 8'hA5;
        do_write(DEF_DEV_ADDR, 8'h05, 1, "wr_prep");
        i2c_start();
        send_byte({DEF_DEV_ADDR, 1'b0}, a);
        check("rstrd_waack", a, 0);
        send_byte(8'h05, a);
        check("rstrd_pack", a, 0);
        i2c_start();
        send_byte({DEF_DEV_ADDR, 1'b1}, a);
        check("rstrd_raack", a, 0);
        for (int i = 0; i < 4; i++) clk_bit(1'b1, b);
        #40;
        m_low = 1'b0;
        #(2*q - 40);
        scl = 1'b1;
        #(q);
        check("rstrd_drive", sda_bus, 0);
        rstn = 1'b0;
        #1;
        check("rstrd_release", sda_bus, 1);
        check("rstrd_busy", obs_if.busy, 0);
        check("rstrd_waddr", obs_if.wr_addr, 0);
        check("rstrd_wdata", obs_if.wr_data, 0);
        #(q - 1);
        scl = 1'b0;
        #100;
        rstn = 1'b1;
        for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
        mptr = 0;
        strb_q.delete();
        exp_q.delete();
        i2c_stop();
        do_read(1'b1, 8'h00, 16, "rd_post_rst");

        wbuf[0] = 8'h59; wbuf[1] = 8'h23;
        do_write(DEF_DEV_ADDR, 8'h03, 2, "wr_post_rst");
        do_read(1'b1, 8'h02, 3, "rd_post_wr");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pcf8563_i2c_slave.md
# pcf8563_i2c_slave

Synthesizable I2C target that emulates the PCF8563 RTC register interface, answering at 7-bit address 0x51 with a 16-byte register file. It is the responder end of the bus that our I2C RTC controller drives. It lets the UART/RTC/display path run on boards without the physical chip, and serves as an in-loop bus model for system simulation. It exposes a write-strobe port so surrounding logic can observe what the controller programs.

## Interface
- DEV_ADDR, 7'h51, 7-bit target address matched after START.
- REG_NUM, 16, register file depth; pointer width is log2(REG_NUM).
- clk  in  1  system clock, 50 MHz nominal; must be at least 20× SCL frequency.
- rstn  in  1  asynchronous, active-low reset.
- i2c_sclk  in  1  bus clock from the controller, asynchronous to clk.
- i2c_sdat  inout  1  open-drain data; this block drives only 0 or Z.
- wr_strobe  out  1  one-clk pulse per data byte written into the register file.
- wr_addr  out  log2(REG_NUM)  register index of the last write.
- wr_data  out  8  byte of the last write.
- busy  out  1  high from an address-matched START until STOP or NACK-terminated read.

## Operation
- Pin front end:
  - sclk and sdat each pass through a 2-FF synchronizer, then a 1-FF edge register.
  - Derived events: scl_rise, scl_fall, START (sda falls while scl high), STOP (sda rises while scl high).
- START from any state, including a repeated START: go to ADDR, clear bit counter, release SDA.
- STOP from any state: go to IDLE and release SDA. Pointer and registers are retained.
- Receive bits are sampled on scl_rise, MSB first. Transmit bits change on scl_fall.
- FSM states and transitions:
  - IDLE: wait for START.
  - ADDR: shift 8 bits.
    - bits[7:1]==DEV_ADDR: go to ADDR_ACK.
    - No match: go to IDLE with SDA untouched until the next START.
  - ADDR_ACK: drive SDA=0 from the scl_fall after bit 8 to the next scl_fall. R/W=0 goes to WPTR; R/W=1 goes to RDATA.
  - WPTR: shift 8 bits, then ACK; pointer <= byte[log2(REG_NUM)-1:0]. Go to WDATA.
  - WDATA: shift 8 bits, then ACK.
    - regs[ptr] <= byte; wr_strobe pulses for 1 clk on the scl_fall that starts the ACK.
    - ptr <= ptr+1 modulo REG_NUM (0x0F wraps to 0x00). Stay in WDATA.
  - RDATA: load regs[ptr] at entry. Drive each bit as open-drain (0 = drive low, 1 = Z) on successive scl_fall. After 8 bits release SDA and go to RACK; ptr increments with wrap.
  - RACK: sample SDA on scl_rise.
    - 0 (ACK): go to RDATA with the next byte.
    - 1 (NACK): go to IDLE-wait, releasing SDA and ignoring SCL until START/STOP.
- A write to address 0x00–0x0F of more than REG_NUM bytes simply wraps and overwrites.
- Simultaneous START and data event cannot occur in one clk (START requires scl high, no edge). If STOP and scl_fall are reported together, STOP wins.

## Timing
- Pin-to-event latency: 3 clk (2 sync + 1 edge).
- SDA drive change occurs 1 clk after the scl_fall event, i.e. 4 clk after the pin edge. This is well inside the tHD;DAT budget at 400 kHz / 50 MHz.
- wr_strobe is high exactly 1 clk. wr_addr/wr_data update in the same clk and hold until the next write.
- Reset values:
  - SDA released (Z); state IDLE; pointer 0.
  - All registers 0x00.
  - wr_strobe 0, wr_addr 0, wr_data 0x00, busy 0.
- Reset asserted mid-transfer releases SDA asynchronously in the same instant. The controller sees NACK/arbitration loss.

## Structure
- Shared package pcf8563_slave_pkg:
  - FSM state enum (IDLE, ADDR, ADDR_ACK, WPTR, WPTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, WAIT_P).
  - Default DEV_ADDR constant.
  - PCF8563 register index constants (SECONDS=0x02 … YEARS=0x08).
- One sub-module: i2c_pin_sync. It holds the synchronizers and edge register and outputs scl_rise, scl_fall, start_det, stop_det, sda_s.
- Register file is a flop array inside the top; no RAM inference needed at 16 bytes.

## Test plan
- Write 0x51/W, ptr 0x02, data 0x45,0x30,0x12, STOP -> ACK on all 5 bytes; regs[2..4]=45,30,12; wr_strobe pulses 3 times with wr_addr 2,3,4.
- Repeated-START read: 0x51/W, ptr 0x02, Sr, 0x51/R, read 3 bytes with ACK,ACK,NACK, STOP -> SDA returns 0x45,0x30,0x12; busy falls on NACK.
- Address 0x50 write -> no ACK (SDA stays Z for the whole frame); no register change; busy stays 0.
- Write ptr 0x0E then 4 data bytes -> regs 0x0E,0x0F,0x00,0x01 written in that order (wrap).
- rstn pulsed low during the 5th bit of a read byte -> SDA released immediately; regs cleared; next valid transaction from START completes normally.
- SCL at 400 kHz with 50 MHz clk and sdat glitch-free -> every ACK/data bit stable ≥1 µs before scl_rise.
